// File: rtl/dxp_cpu2.sv
// dxp_cpu2: 4-bit accumulator CPU with a hard-coded 16x8 program ROM and a 3-cycle FETCH/DECODE/EXECUTE FSM.
// Optional macro SINGLE_STEP_EN: FETCH waits for a rising edge on PB_in[3].
module dxp_cpu2 #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] SW_in,
    input  logic [3:0] PB_in,
    output logic [3:0] DHR_out,
    output logic [3:0] DLR_out
);

    localparam int unsigned DW = 4;
    localparam int unsigned AW = 4;
    localparam int unsigned IW = 8;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic          z_q, z_d;
    logic          c_q, c_d;
    logic [DW-1:0] dhr_q, dhr_d;
    logic [DW-1:0] dlr_q, dlr_d;

    logic [3:0]    opc;
    logic [DW-1:0] k;
    logic [DW:0]   sum;
    logic          fetch_go;

    function automatic logic [IW-1:0] rom(input logic [AW-1:0] addr);
        case (addr)
            4'h0:    rom = 8'h30;
            4'h1:    rom = 8'hD1;
            4'h2:    rom = 8'hA0;
            4'h3:    rom = 8'h20;
            4'h4:    rom = 8'h80;
            4'h5:    rom = 8'h60;
            4'h6:    rom = 8'h50;
            4'h7:    rom = 8'h70;
            4'h8:    rom = 8'h30;
            4'h9:    rom = 8'hD1;
            4'hA:    rom = 8'hB8;
            4'hB:    rom = 8'h90;
            default: rom = 8'h00;
        endcase
    endfunction

`ifdef SINGLE_STEP_EN
    logic pb3_q, pb3_d;

    // Previous PB_in[3] sample for rising-edge detection.
    always_ff @(posedge Clock) begin
        if (Reset) pb3_q <= 1'b0;
        else       pb3_q <= pb3_d;
    end

    assign pb3_d    = PB_in[3];
    assign fetch_go = PB_in[3] & ~pb3_q;
`else
    assign fetch_go = 1'b1;
`endif

    assign opc = ir_q[7:4];
    assign k   = ir_q[3:0];
    assign sum = {1'b0, a_q} + {1'b0, (opc == 4'h5) ? b_q : k};

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        c_d     = c_q;
        dhr_d   = dhr_q;
        dlr_d   = dlr_q;

        case (state_q)
            S_FETCH: begin
                if (fetch_go) begin
                    ir_d    = rom(pc_q);
                    pc_d    = pc_q + 4'd1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                state_d = S_FETCH;
                case (opc)
                    4'h1: begin a_d = k;          z_d = (k == '0);          end
                    4'h2: begin a_d = SW_in;      z_d = (SW_in == '0);      end
                    4'h3: begin a_d = PB_in;      z_d = (PB_in == '0);      end
                    4'h4, 4'h5: begin
                        a_d = sum[DW-1:0];
                        c_d = sum[DW];
                        z_d = (sum[DW-1:0] == '0);
                    end
                    4'h6: b_d   = a_q;
                    4'h7: dhr_d = a_q;
                    4'h8: dlr_d = a_q;
                    4'h9: pc_d  = k;
                    4'hA: if (z_q)  pc_d = k;
                    4'hB: if (!z_q) pc_d = k;
                    4'hC: if (c_q)  pc_d = k;
                    4'hD: begin a_d = a_q & k;    z_d = ((a_q & k) == '0);  end
                    4'hE: begin a_d = a_q ^ k;    z_d = ((a_q ^ k) == '0);  end
                    // HALT undoes the FETCH increment so it refetches itself.
                    4'hF: pc_d = pc_q - 4'd1;
                    default: ;
                endcase
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            dhr_q   <= '0;
            dlr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            c_q     <= c_d;
            dhr_q   <= dhr_d;
            dlr_q   <= dlr_d;
        end
    end

    assign DHR_out = dhr_q;
    assign DLR_out = dlr_q;

endmodule

// File: tb/tb_dxp_cpu2.sv
// Self-checking bench for dxp_cpu2: scoreboard of expected display values popped on each output change.
module tb_dxp_cpu2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw  = 4'h0;
    logic [3:0] pb  = 4'h0;
    logic [3:0] dhr;
    logic [3:0] dlr;

    int checks = 0;
    int passed = 0;
    logic [7:0] exp_q[$];

    dxp_cpu2 dut (
        .Clock  (clk),
        .Reset  (rst),
        .SW_in  (sw),
        .PB_in  (pb),
        .DHR_out(dhr),
        .DLR_out(dlr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance until {DHR,DLR} changes or the budget runs out.
    task automatic wait_change(input int budget, output bit seen, output int used);
        logic [7:0] prev;
        prev = {dhr, dlr};
        seen = 1'b0;
        used = 0;
        while (!seen && used < budget) begin
            tick();
            used++;
            if ({dhr, dlr} !== prev) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sw = 4'h0; pb = 4'h0;
        tick(); tick();
        checks++; if ({dhr, dlr} !== 8'h00) $display("FAIL reset_out got %h want 00", {dhr, dlr}); else passed++;
        checks++; if (dut.pc_q !== 4'h0) $display("FAIL reset_pc got %h want 0", dut.pc_q); else passed++;
        checks++; if (dut.a_q !== 4'h0) $display("FAIL reset_a got %h want 0", dut.a_q); else passed++;
    endtask

    task automatic test_idle_loop();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (20) tick();
            checks++; if ({dhr, dlr} !== 8'h00) $display("FAIL idle_out[%0d] got %h want 00", i, {dhr, dlr}); else passed++;
            checks++; if (dut.pc_q > 4'h3) $display("FAIL idle_pc[%0d] got %h want <=3", i, dut.pc_q); else passed++;
        end
    endtask

    // Press PB0 with given switches; DLR updates first, then DHR.
    task automatic test_press(input logic [3:0] sw_v, input logic [3:0] hi, input logic [3:0] lo);
        logic [7:0] e;
        bit seen;
        int used;
        int total;
        total = 0;
        exp_q.push_back({dhr, lo});
        exp_q.push_back({hi, lo});
        sw = sw_v;
        pb = 4'b0001;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_change(45, seen, used);
            total += used;
            checks++;
            if (!seen) $display("FAIL press_sw%h timeout got %h want %h", sw_v, {dhr, dlr}, e);
            else if ({dhr, dlr} !== e) $display("FAIL press_sw%h got %h want %h", sw_v, {dhr, dlr}, e);
            else passed++;
        end
        checks++; if (total > 45) $display("FAIL press_latency_sw%h got %0d clocks want <=45", sw_v, total); else passed++;
    endtask

    task automatic test_hold();
        pb = 4'h0;
        repeat (30) tick();
        checks++; if ({dhr, dlr} !== 8'hA5) $display("FAIL hold_release got %h want a5", {dhr, dlr}); else passed++;
        sw = 4'hA;
        repeat (30) tick();
        checks++; if ({dhr, dlr} !== 8'hA5) $display("FAIL hold_sw_change got %h want a5", {dhr, dlr}); else passed++;
        checks++; if (dut.pc_q > 4'h3) $display("FAIL hold_wait_loop pc got %h want <=3", dut.pc_q); else passed++;
    endtask

    task automatic test_carry_stable();
        checks++; if (dut.c_q !== 1'b1) $display("FAIL carry_flag got %b want 1", dut.c_q); else passed++;
        for (int i = 0; i < 3; i++) begin
            repeat (10) tick();
            checks++; if ({dhr, dlr} !== 8'h4A) $display("FAIL held_stable[%0d] got %h want 4a", i, {dhr, dlr}); else passed++;
        end
    endtask

    task automatic test_reset_in_outh();
        int n;
        pb = 4'h0;
        repeat (30) tick();
        sw = 4'h3;
        pb = 4'b0001;
        n = 0;
        while (dut.ir_q !== 8'h70 && n < 60) begin tick(); n++; end
        checks++; if (dut.ir_q !== 8'h70) $display("FAIL outh_reach got ir %h want 70", dut.ir_q); else passed++;
        tick();
        checks++; if ({dhr, dlr} !== 8'h43) $display("FAIL outh_pre got %h want 43", {dhr, dlr}); else passed++;
        rst = 1'b1;
        tick();
        checks++; if (dhr !== 4'h0) $display("FAIL outh_abort_dhr got %h want 0", dhr); else passed++;
        checks++; if (dlr !== 4'h0) $display("FAIL outh_abort_dlr got %h want 0", dlr); else passed++;
        checks++; if (dut.pc_q !== 4'h0) $display("FAIL outh_abort_pc got %h want 0", dut.pc_q); else passed++;
        rst = 1'b0;
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_single_step();
        logic [3:0] exp_pc[3];
        exp_pc[0] = 4'h1; exp_pc[1] = 4'h2; exp_pc[2] = 4'h0;
        rst = 1'b1; pb = 4'h0; tick(); tick(); rst = 1'b0;
        repeat (6) tick();
        checks++; if (dut.pc_q !== 4'h0) $display("FAIL ss_idle_pc got %h want 0", dut.pc_q); else passed++;
        for (int i = 0; i < 3; i++) begin
            pb = 4'b1000; tick();
            pb = 4'b0000; repeat (6) tick();
            checks++; if (dut.pc_q !== exp_pc[i]) $display("FAIL ss_pulse[%0d] pc got %h want %h", i, dut.pc_q, exp_pc[i]); else passed++;
        end
        rst = 1'b1; pb = 4'b1000; tick(); tick(); rst = 1'b0;
        repeat (20) tick();
        checks++; if (dut.pc_q !== 4'h1) $display("FAIL ss_held_pc got %h want 1", dut.pc_q); else passed++;
        checks++; if (dut.a_q !== 4'h8) $display("FAIL ss_held_a got %h want 8", dut.a_q); else passed++;
        pb = 4'h0;
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_idle_loop();
`ifdef SINGLE_STEP_EN
        test_single_step();
`else
        test_press(4'h5, 4'hA, 4'h5);
        test_hold();
        test_press(4'hA, 4'h4, 4'hA);
        test_carry_stable();
        test_reset_in_outh();
        test_press(4'h3, 4'h6, 4'h3);
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dxp_cpu2.md
Name: dxp_cpu2

Overview:
- Small 4-bit accumulator CPU for board bring-up: 4 switches and 4 pushbuttons in, two 4-bit display registers out.
- Contains a hard-coded 16x8 program ROM, a multicycle control FSM, an accumulator A, a helper register B, and Z/C flags.
- Top-level board demo block. Display outputs feed hex/LED drivers.

Parameters:
- RESET_PC, 4'h0, PC value loaded on reset and the program entry point.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- SW_in  input  4  slide switches; sampled directly by INSW.
- PB_in  input  4  pushbuttons, 1 = pressed; sampled directly by INPB.
- DHR_out  output  4  display high register, written by OUTH.
- DLR_out  output  4  display low register, written by OUTL.

Behaviour:
- Reset, sampled on the clock edge:
  - PC=RESET_PC, IR=0, A=0, B=0, Z=0, C=0.
  - DHR_out=0, DLR_out=0, FSM=FETCH.
  - Reset mid-instruction aborts that instruction with no partial writes.
- FSM states and cycles:
  - FETCH: IR<=ROM[PC], PC<=PC+1 (4-bit wrap, F->0).
  - DECODE: IR held; no architectural change.
  - EXECUTE: perform the operation, then return to FETCH.
  - Every instruction takes exactly 3 clocks.
  - Register and output writes are visible the cycle after EXECUTE.
- Instruction format: IR[7:4]=opcode, IR[3:0]=k (immediate or absolute address).
- Opcodes:
  - 0 NOP.
  - 1 LDI: A=k.
  - 2 INSW: A=SW_in.
  - 3 INPB: A=PB_in.
  - 4 ADDI: {C,A}=A+k.
  - 5 ADDB: {C,A}=A+B.
  - 6 MOVB: B=A.
  - 7 OUTH: DHR=A.
  - 8 OUTL: DLR=A.
  - 9 JMP: PC=k.
  - A JZ: if Z then PC=k.
  - B JNZ: if !Z then PC=k.
  - C JC: if C then PC=k.
  - D ANDI: A=A&k.
  - E XORI: A=A^k.
  - F HALT: PC stays on the HALT; the CPU re-executes it forever, leaving only Reset.
- Flags:
  - Z is updated by opcodes 1,2,3,4,5,D,E to (new A==0).
  - C is updated only by ADDI/ADDB. Logic ops leave C unchanged.
  - Other opcodes leave both flags unchanged.
- Arithmetic is 4-bit unsigned; the carry-out goes to C.
- Outputs are registered and hold until the next OUTH/OUTL.
- Default ROM program (address: instruction):
  - 0: INPB (30)
  - 1: ANDI 1 (D1)
  - 2: JZ 0 (A0)
  - 3: INSW (20)
  - 4: OUTL (80)
  - 5: MOVB (60)
  - 6: ADDB (50)
  - 7: OUTH (70)
  - 8: INPB (30)
  - 9: ANDI 1 (D1)
  - A: JNZ 8 (B8)
  - B: JMP 0 (90)
  - C..F: NOP.
- Program function:
  - Waits for a PB_in[0] press.
  - Shows the switches on DLR and 2*SW mod 16 on DHR.
  - Waits for release, then repeats.
- Inputs are used unsynchronised. Any debouncing or synchronisation happens upstream.

Optional Feature:
- SINGLE_STEP_EN.
- When defined:
  - PB_in[3] is registered each clock.
  - FETCH only advances when a rising edge of PB_in[3] is detected (previous 0, current 1).
  - Otherwise the FSM holds in FETCH with no state changes.
  - DECODE and EXECUTE follow automatically.
  - Default program behaviour is unchanged apart from pacing.
- When undefined: free-running 3-cycle instruction timing; PB_in[3] is an ordinary input bit.

Test Plan:
- Reset=1 for 2 clocks with SW=0, PB=0 -> DHR_out=0, DLR_out=0. With Reset low and PB=0 for 100 clocks, outputs stay 0 (loop at 0-2).
- SW=0101, PB=0001 for 30 clocks -> DLR_out=4'h5, DHR_out=4'hA. The first output write lands within 15 instructions of release from reset.
- PB=0000 for 30 clocks, then SW=1010 with PB=0000 for 30 clocks -> outputs hold 5/A. The CPU cycles through the wait loop.
- SW=1010, PB=0001 -> DLR_out=4'hA, DHR_out=4'h4 (C set internally). Outputs are stable while PB is held.
- Assert Reset during EXECUTE of OUTH -> DHR_out=0 next cycle and PC=0.
- With SINGLE_STEP_EN: three PB_in[3] pulses -> exactly 3 instructions executed. With PB_in[3] held at 1, only one instruction executes.
